ycr1_imem_router_np: RTL and testbench
======================================

YCR1_IMEM_ROUTER_NP -- requirements
Module: ycr1_imem_router_np

Interface
REQ-001 SHALL provide parameter N_PORTS, default 4, meaning number of downstream ports (range 1..8).
REQ-002 SHALL provide parameter MAX_OUTST, default 2, meaning maximum accepted-but-unanswered requests (range 1..8).
REQ-003 SHALL provide parameter ADDR_MASK, default N_PORTS x `YCR1_IMEM_AWIDTH'hFFFF0000, meaning packed per-port address mask.
REQ-004 SHALL provide parameter ADDR_PATTERN, default {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000} (index 0 rightmost), meaning packed per-port match pattern.
REQ-005 clk  in  1  core clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 imem_req / imem_cmd / imem_addr / imem_bl  in  1 / 1 / `YCR1_IMEM_AWIDTH / `YCR1_IMEM_BSIZE  core request.
REQ-008 imem_req_ack  out  1  core request accepted this cycle.
REQ-009 imem_rdata / imem_resp  out  `YCR1_IMEM_DWIDTH / 2  core response.
REQ-010 port_req  out  N_PORTS  per-port request.
REQ-011 port_req_ack  in  N_PORTS  per-port accept.
REQ-012 port_cmd / port_addr / port_bl  out  1 / `YCR1_IMEM_AWIDTH / `YCR1_IMEM_BSIZE  broadcast command, address, burst length.
REQ-013 port_rdata / port_resp  in  N_PORTS x `YCR1_IMEM_DWIDTH / N_PORTS x 2  packed per-port response.

Function
REQ-014 Decode SHALL be combinational: target = lowest index i with (imem_addr & ADDR_MASK[i]) == ADDR_PATTERN[i]; no match -> target = internal error sink (ERR).
REQ-015 Router SHALL keep an in-order tag FIFO of depth MAX_OUTST holding target IDs ($clog2(N_PORTS+1) bits, ERR = N_PORTS).
REQ-016 pop SHALL assert when FIFO non-empty and head response != YCR1_MEM_RESP_NOTRDY.
REQ-017 space SHALL be (!full | pop); same_tgt SHALL be (empty | (count==1 & pop) | target == tail ID).
REQ-018 port_req[i] SHALL equal imem_req & space & same_tgt & (target == i); all other bits zero.
REQ-019 imem_req_ack SHALL equal port_req_ack[target] gated by the port_req condition; for ERR, imem_req & space & same_tgt.
REQ-020 Push SHALL occur on imem_req & imem_req_ack; simultaneous push and pop SHALL leave count unchanged and stay legal when full.
REQ-021 Response mux SHALL select by FIFO head: port head -> port_rdata/port_resp of that port; ERR head -> rdata '0, resp YCR1_MEM_RESP_RDY_ER; empty -> rdata '0, resp YCR1_MEM_RESP_NOTRDY.
REQ-022 ERR response SHALL appear earliest one cycle after acceptance; port responses earliest one cycle after acceptance (combinational pass-through from head).
REQ-023 Responses from a port that is not at head SHALL be ignored; switching target SHALL stall until the FIFO drains, guaranteeing order.
REQ-024 Pointers SHALL wrap modulo MAX_OUTST; count SHALL saturate neither up nor down (overflow and underflow impossible by REQ-017/REQ-016).
REQ-025 port_cmd, port_addr and port_bl SHALL be driven directly from imem_cmd, imem_addr and imem_bl (no X-prop gating).

Reset
REQ-026 On rst_n low: FIFO empty, pointers and count 0, all port_req 0, imem_req_ack 0, imem_resp YCR1_MEM_RESP_NOTRDY, imem_rdata '0.
REQ-027 Reset asserted mid-transaction SHALL discard all outstanding tags; late port responses after release SHALL be ignored (FIFO empty).

Structure
REQ-028 Response/command codes SHALL come from the shared memif package; the router-local tag width localparam and ERR ID SHALL stay in-module.
REQ-029 Tag FIFO SHALL be a sub-module ycr1_tag_fifo (params WIDTH, DEPTH; push, pop, full, empty, head, tail, count).
REQ-030 Simulation assertions SHALL flag: unknown imem_addr with imem_req; any port_resp != NOTRDY when that port is not head; overlapping ADDR_PATTERN matches as a warning.

Verification
REQ-031 Addr 0x0001_0040 req, port1 acks, resp RDY_OK next cycle with rdata 0xDEAD_BEEF -> imem_rdata 0xDEAD_BEEF, count back to 0.
REQ-032 MAX_OUTST=2, three back-to-back reqs to port2, port2 acks always, first resp delayed 3 cycles -> third req stalls (ack 0) until first RDY_OK pop cycle, then accepted same cycle.
REQ-033 Req to 0x0001_0000 then 0x0002_0000 while first outstanding -> port2_req stays 0 until port1 response pops; then issued.
REQ-034 Addr 0x8000_0000 (unmapped) -> ack same cycle, no port_req, imem_resp RDY_ER next cycle, rdata 0.
REQ-035 Two reqs outstanding to port0, rst_n pulsed low -> all outputs at reset values; port0 RDY_OK after release -> imem_resp NOTRDY.

Source files
------------

// File: rtl/ycr1_imem_router_np_pkg.sv
// Shared instruction-memory interface definitions used by the router,
// its tag FIFO and anything that talks the imem protocol.
//   - bus widths (address, data, burst length)
//   - command and response codes
//   - per-port address decode helper
package ycr1_imem_router_np_pkg;

    localparam int unsigned YCR1_IMEM_AWIDTH = 32;
    localparam int unsigned YCR1_IMEM_DWIDTH = 32;
    localparam int unsigned YCR1_IMEM_BSIZE  = 3;
    localparam int unsigned YCR1_MEM_RESP_W  = 2;

    typedef enum logic [YCR1_MEM_RESP_W-1:0] {
        YCR1_MEM_RESP_NOTRDY     = 2'b00,
        YCR1_MEM_RESP_RDY_OK     = 2'b01,
        YCR1_MEM_RESP_RDY_ER     = 2'b10,
        YCR1_MEM_RESP_RDY_LOCKED = 2'b11
    } ycr1_mem_resp_e;

    typedef enum logic {
        YCR1_MEM_CMD_RD = 1'b0,
        YCR1_MEM_CMD_WR = 1'b1
    } ycr1_mem_cmd_e;

    // Response payload as seen by the core
    typedef struct packed {
        logic [YCR1_IMEM_DWIDTH-1:0] rdata;
        logic [YCR1_MEM_RESP_W-1:0]  resp;
    } ycr1_imem_rsp_t;

    // True when addr falls into the window described by mask/pattern
    function automatic logic addr_match(
        input logic [YCR1_IMEM_AWIDTH-1:0] addr,
        input logic [YCR1_IMEM_AWIDTH-1:0] mask,
        input logic [YCR1_IMEM_AWIDTH-1:0] pattern
    );
        return (addr & mask) == pattern;
    endfunction

endpackage

// File: rtl/ycr1_tag_fifo.sv
// In-order tag FIFO: remembers which target owns each outstanding request.
// Ports:
//   clk, rst_n        clock, async active-low reset (empties the FIFO)
//   push, din         write din at tail (caller guarantees !full | pop)
//   pop               drop head entry (caller guarantees !empty)
//   head, tail        oldest and most recently pushed entries
//   full, empty       occupancy flags
//   count             number of valid entries
module ycr1_tag_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               head,
    output logic [WIDTH-1:0]               tail,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] last_ptr;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    assign last_ptr = (wr_ptr == '0) ? LAST_IDX : wr_ptr - PTR_W'(1);
    assign head     = mem[rd_ptr];
    assign tail     = mem[last_ptr];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ycr1_imem_router_np.sv
// Non-pipelined-response instruction memory router: decodes the core
// request address onto one of N_PORTS downstream ports (or an internal
// error sink), keeps responses in order with a tag FIFO and returns the
// head target's response straight through to the core.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   imem_req/cmd/addr/bl, imem_req_ack  core request channel
//   imem_rdata, imem_resp               core response (combinational from head)
//   port_req, port_req_ack              per-port request handshake
//   port_cmd/addr/bl                    command broadcast to every port
//   port_rdata, port_resp               packed per-port responses
module ycr1_imem_router_np
    import ycr1_imem_router_np_pkg::*;
#(
    parameter int unsigned N_PORTS   = 4,
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [N_PORTS*YCR1_IMEM_AWIDTH-1:0] ADDR_MASK =
        {N_PORTS{YCR1_IMEM_AWIDTH'(32'hFFFF_0000)}},
    parameter logic [N_PORTS*YCR1_IMEM_AWIDTH-1:0] ADDR_PATTERN =
        {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000}
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  imem_req,
    input  logic                                  imem_cmd,
    input  logic [YCR1_IMEM_AWIDTH-1:0]           imem_addr,
    input  logic [YCR1_IMEM_BSIZE-1:0]            imem_bl,
    output logic                                  imem_req_ack,
    output logic [YCR1_IMEM_DWIDTH-1:0]           imem_rdata,
    output logic [YCR1_MEM_RESP_W-1:0]            imem_resp,
    output logic [N_PORTS-1:0]                    port_req,
    input  logic [N_PORTS-1:0]                    port_req_ack,
    output logic                                  port_cmd,
    output logic [YCR1_IMEM_AWIDTH-1:0]           port_addr,
    output logic [YCR1_IMEM_BSIZE-1:0]            port_bl,
    input  logic [N_PORTS*YCR1_IMEM_DWIDTH-1:0]   port_rdata,
    input  logic [N_PORTS*YCR1_MEM_RESP_W-1:0]    port_resp
);

    localparam int unsigned TAG_W = $clog2(N_PORTS + 1);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    localparam int unsigned AW    = YCR1_IMEM_AWIDTH;
    localparam int unsigned DW    = YCR1_IMEM_DWIDTH;
    localparam int unsigned RW    = YCR1_MEM_RESP_W;
    localparam logic [TAG_W-1:0] ERR_ID = TAG_W'(N_PORTS);

    logic [N_PORTS-1:0] match_vec;
    logic [TAG_W-1:0]   target;
    logic [TAG_W-1:0]   head_id;
    logic [TAG_W-1:0]   tail_id;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               space;
    logic               same_tgt;
    logic               issue_ok;
    logic [DW-1:0]      head_rdata;
    logic [RW-1:0]      head_resp;

    // Commands are broadcast untouched; only port_req qualifies them
    assign port_cmd  = imem_cmd;
    assign port_addr = imem_addr;
    assign port_bl   = imem_bl;

    // Address decode: lowest matching port wins, no match goes to ERR
    always_comb begin
        match_vec = '0;
        target    = ERR_ID;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            match_vec[i] = addr_match(imem_addr, ADDR_MASK[i*AW +: AW],
                                      ADDR_PATTERN[i*AW +: AW]);
            if (match_vec[i]) begin
                target = TAG_W'(i);
            end
        end
    end

    // Issue only with FIFO room and when order can't be violated; the
    // rst_n term keeps requests off the ports while reset is held
    assign space    = !fifo_full || pop;
    assign same_tgt = fifo_empty || ((fifo_count == CNT_W'(1)) && pop) ||
                      (target == tail_id);
    assign issue_ok = imem_req && space && same_tgt && rst_n;

    // Request fan-out and accept selection
    always_comb begin
        port_req     = '0;
        imem_req_ack = 1'b0;
        if (target == ERR_ID) begin
            imem_req_ack = issue_ok;
        end
        for (int i = 0; i < int'(N_PORTS); i++) begin
            if (target == TAG_W'(i)) begin
                port_req[i]  = issue_ok;
                imem_req_ack = issue_ok && port_req_ack[i];
            end
        end
    end

    assign push = imem_req && imem_req_ack;

    // Response mux driven by the oldest outstanding tag
    always_comb begin
        head_rdata = '0;
        head_resp  = YCR1_MEM_RESP_NOTRDY;
        if (!fifo_empty) begin
            if (head_id == ERR_ID) begin
                head_resp = YCR1_MEM_RESP_RDY_ER;
            end
            for (int i = 0; i < int'(N_PORTS); i++) begin
                if (head_id == TAG_W'(i)) begin
                    head_rdata = port_rdata[i*DW +: DW];
                    head_resp  = port_resp[i*RW +: RW];
                end
            end
        end
    end

    assign pop        = !fifo_empty && (head_resp != YCR1_MEM_RESP_NOTRDY);
    assign imem_rdata = head_rdata;
    assign imem_resp  = head_resp;

    ycr1_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (target),
        .head  (head_id),
        .tail  (tail_id),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifndef SYNTHESIS
    // Protocol sanity checks
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(imem_req && $isunknown(imem_addr)))
                else $error("imem_addr unknown while imem_req asserted");
            if (imem_req && ($countones(match_vec) > 1)) begin
                $warning("address 0x%08h matches several port windows", imem_addr);
            end
            for (int i = 0; i < int'(N_PORTS); i++) begin
                if ((port_resp[i*RW +: RW] != YCR1_MEM_RESP_NOTRDY) &&
                    (fifo_empty || (head_id != TAG_W'(i)))) begin
                    $warning("port %0d responded while not at head; ignored", i);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ycr1_imem_router_np.sv
// Scoreboard bench for ycr1_imem_router_np with directed vectors.
module tb_ycr1_imem_router_np;
    import ycr1_imem_router_np_pkg::*;

    localparam int unsigned NP = 4;

    logic            clk;
    logic            rst_n;
    logic            imem_req;
    logic            imem_cmd;
    logic [31:0]     imem_addr;
    logic [2:0]      imem_bl;
    logic            imem_req_ack;
    logic [31:0]     imem_rdata;
    logic [1:0]      imem_resp;
    logic [NP-1:0]   port_req;
    logic [NP-1:0]   port_req_ack;
    logic            port_cmd;
    logic [31:0]     port_addr;
    logic [2:0]      port_bl;
    logic [NP*32-1:0] port_rdata;
    logic [NP*2-1:0]  port_resp;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    ycr1_imem_router_np #(
        .N_PORTS   (NP),
        .MAX_OUTST (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_cmd     (imem_cmd),
        .imem_addr    (imem_addr),
        .imem_bl      (imem_bl),
        .imem_req_ack (imem_req_ack),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .port_req     (port_req),
        .port_req_ack (port_req_ack),
        .port_cmd     (port_cmd),
        .port_addr    (port_addr),
        .port_bl      (port_bl),
        .port_rdata   (port_rdata),
        .port_resp    (port_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic [NP-1:0] ack);
        imem_req     = 1'b1;
        imem_addr    = addr;
        port_req_ack = ack;
    endtask

    task automatic idle();
        imem_req     = 1'b0;
        port_req_ack = '0;
    endtask

    task automatic set_resp(input int p, input logic [1:0] r, input logic [31:0] d);
        port_resp[p*2 +: 2]   = r;
        port_rdata[p*32 +: 32] = d;
    endtask

    task automatic clr_resps();
        port_resp  = '0;
        port_rdata = '0;
    endtask

    task automatic expect_rsp(input logic [31:0] d, input logic [1:0] r);
        exp_t e;
        e.rdata = d;
        e.resp  = r;
        exp_q.push_back(e);
    endtask

    // Monitor: every non-NOTRDY core response must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (imem_resp != YCR1_MEM_RESP_NOTRDY)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got resp %0d rdata 0x%08h, none expected", imem_resp, imem_rdata);
            end else begin
                e = exp_q.pop_front();
                check("sb_resp", imem_resp, e.resp);
                check("sb_rdata", imem_rdata, e.rdata);
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        imem_req     = 1'b0;
        imem_cmd     = YCR1_MEM_CMD_RD;
        imem_addr    = '0;
        imem_bl      = 3'd1;
        port_req_ack = '0;
        port_rdata   = '0;
        port_resp    = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_port_req", port_req, 0);
        check("rst_ack", imem_req_ack, 0);
        check("rst_resp", imem_resp, YCR1_MEM_RESP_NOTRDY);
        check("rst_rdata", imem_rdata, 0);
        check("rst_count", dut.u_tag_fifo.count, 0);
        next_cycle(); rst_n = 1'b1;
        next_cycle();

        // Single request to port1
        next_cycle(); drive_req(32'h0001_0040, 4'b0010);
        expect_rsp(32'hDEAD_BEEF, YCR1_MEM_RESP_RDY_OK);
        @(negedge clk);
        check("A_port_req", port_req, 4'b0010);
        check("A_ack", imem_req_ack, 1);
        check("A_port_addr", port_addr, 32'h0001_0040);
        next_cycle(); idle(); set_resp(1, YCR1_MEM_RESP_RDY_OK, 32'hDEAD_BEEF);
        next_cycle(); clr_resps();
        @(negedge clk);
        check("A_count", dut.u_tag_fifo.count, 0);
        check("A_resp_idle", imem_resp, YCR1_MEM_RESP_NOTRDY);

        // Three back-to-back to port2, FIFO depth 2
        next_cycle(); drive_req(32'h0002_0000, 4'b0100);
        expect_rsp(32'h1111_0000, YCR1_MEM_RESP_RDY_OK);
        @(negedge clk); check("B_ack0", imem_req_ack, 1);
        next_cycle(); drive_req(32'h0002_0004, 4'b0100);
        expect_rsp(32'h1111_0001, YCR1_MEM_RESP_RDY_OK);
        @(negedge clk); check("B_ack1", imem_req_ack, 1);
        next_cycle(); drive_req(32'h0002_0008, 4'b0100);
        @(negedge clk);
        check("B_stall_ack", imem_req_ack, 0);
        check("B_stall_req", port_req, 0);
        next_cycle();
        set_resp(2, YCR1_MEM_RESP_RDY_OK, 32'h1111_0000);
        expect_rsp(32'h1111_0002, YCR1_MEM_RESP_RDY_OK);
        @(negedge clk);
        check("B_pop_ack", imem_req_ack, 1);
        check("B_pop_req", port_req, 4'b0100);
        next_cycle(); idle(); set_resp(2, YCR1_MEM_RESP_RDY_OK, 32'h1111_0001);
        @(negedge clk); check("B_full_count", dut.u_tag_fifo.count, 2);
        next_cycle(); set_resp(2, YCR1_MEM_RESP_RDY_OK, 32'h1111_0002);
        next_cycle(); clr_resps();
        @(negedge clk); check("B_count", dut.u_tag_fifo.count, 0);

        // Target switch waits for the previous target to drain
        next_cycle(); drive_req(32'h0001_0000, 4'b0010);
        expect_rsp(32'hC1C1_C1C1, YCR1_MEM_RESP_RDY_OK);
        @(negedge clk); check("C_ack1", imem_req_ack, 1);
        next_cycle(); drive_req(32'h0002_0000, 4'b0100);
        @(negedge clk);
        check("C_hold_req", port_req, 0);
        check("C_hold_ack", imem_req_ack, 0);
        next_cycle(); set_resp(2, YCR1_MEM_RESP_RDY_OK, 32'h0000_0BAD);
        @(negedge clk);
        check("C_nonhead_resp", imem_resp, YCR1_MEM_RESP_NOTRDY);
        check("C_hold_req2", port_req, 0);
        next_cycle(); clr_resps(); set_resp(1, YCR1_MEM_RESP_RDY_OK, 32'hC1C1_C1C1);
        expect_rsp(32'hC2C2_C2C2, YCR1_MEM_RESP_RDY_OK);
        @(negedge clk);
        check("C_switch_req", port_req, 4'b0100);
        check("C_switch_ack", imem_req_ack, 1);
        next_cycle(); idle(); clr_resps(); set_resp(2, YCR1_MEM_RESP_RDY_OK, 32'hC2C2_C2C2);
        next_cycle(); clr_resps();

        // Unmapped address goes to the error sink
        next_cycle(); drive_req(32'h8000_0000, 4'b1111);
        expect_rsp(32'h0, YCR1_MEM_RESP_RDY_ER);
        @(negedge clk);
        check("D_port_req", port_req, 0);
        check("D_ack", imem_req_ack, 1);
        next_cycle(); idle();
        next_cycle();
        @(negedge clk); check("D_resp_idle", imem_resp, YCR1_MEM_RESP_NOTRDY);

        // Reset with two outstanding tags to port0
        next_cycle(); drive_req(32'h0000_0010, 4'b0001);
        @(negedge clk); check("E_ack0", imem_req_ack, 1);
        next_cycle(); drive_req(32'h0000_0014, 4'b0001);
        @(negedge clk); check("E_ack1", imem_req_ack, 1);
        next_cycle(); rst_n = 1'b0;
        @(negedge clk);
        check("E_rst_port_req", port_req, 0);
        check("E_rst_ack", imem_req_ack, 0);
        check("E_rst_resp", imem_resp, YCR1_MEM_RESP_NOTRDY);
        check("E_rst_rdata", imem_rdata, 0);
        check("E_rst_count", dut.u_tag_fifo.count, 0);
        next_cycle(); idle(); rst_n = 1'b1;
        next_cycle(); set_resp(0, YCR1_MEM_RESP_RDY_OK, 32'h5555_5555);
        @(negedge clk);
        check("E_late_resp", imem_resp, YCR1_MEM_RESP_NOTRDY);
        check("E_late_rdata", imem_rdata, 0);
        next_cycle(); clr_resps();
        repeat (2) next_cycle();

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
